// File: rtl/usb_pkt_rx.sv
// USB packet-layer receiver: decodes PID, token, data and handshake packets from usb_rx byte strobes.
// Build option: define USB_PKT_CRC_CHECK_EN to include the CRC5/CRC16 checkers (otherwise crc_err stays 0).
module usb_pkt_rx #(
    parameter int MAX_DATA = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        valid,
    input  logic        error,
    input  logic [7:0]  data,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [10:0] frame,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        pkt_end,
    output logic        pkt_ok,
    output logic        pid_err,
    output logic        crc_err,
    output logic        len_err,
    output logic        rx_err,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PID   = 3'd1;
    localparam logic [2:0] ST_TOKEN = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_HSK   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_END   = 3'd6;

    localparam int CW = $clog2(MAX_DATA + 4);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    // Largest byte count after the PID: MAX_DATA payload bytes plus two CRC bytes.
    localparam logic [CW-1:0] DATA_LIM = CW'(MAX_DATA + 2);

    // Valid/ready: the upstream usb_rx has no back-pressure; a byte is taken on every clk where valid=1,
    // and data_valid is a one-cycle strobe with no ready, so the consumer must take data_out that cycle.

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    b1_q, b1_d;
    logic [7:0]    buf0_q, buf0_d;
    logic [7:0]    buf1_q, buf1_d;
    logic          silent_q, silent_d;
    logic [3:0]    pid_q, pid_d;
    logic [6:0]    addr_q, addr_d;
    logic [3:0]    endp_q, endp_d;
    logic [10:0]   frame_q, frame_d;
    logic [7:0]    dout_q, dout_d;
    logic          dvalid_q, dvalid_d;
    logic          pkt_end_q, pkt_end_d;
    logic          pkt_ok_q, pkt_ok_d;
    logic          pid_err_q, pid_err_d;
    logic          len_err_q, len_err_d;
    logic          rx_err_q, rx_err_d;
    logic          crc_flag_d;
    logic          take_pid;

`ifdef USB_PKT_CRC_CHECK_EN
    localparam logic [4:0]  CRC5_RES  = 5'b01100;
    localparam logic [15:0] CRC16_RES = 16'h800D;

    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic        crc_err_q, crc_err_d;

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (b[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'h05;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (b[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b1_d      = b1_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        silent_d  = silent_q;
        pid_d     = pid_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        frame_d   = frame_q;
        dout_d    = dout_q;
        dvalid_d  = 1'b0;
        pkt_ok_d  = pkt_ok_q;
        pid_err_d = pid_err_q;
        len_err_d = len_err_q;
        rx_err_d  = rx_err_q;
        take_pid  = 1'b0;
`ifdef USB_PKT_CRC_CHECK_EN
        crc5_d    = crc5_q;
        crc16_d   = crc16_q;
        crc_err_d = crc_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // After reset a packet already in flight is swallowed without reporting it.
                if (silent_q) begin
                    if (active) state_d = ST_DRAIN;
                    else        silent_d = 1'b0;
                end else if (active) begin
                    state_d   = ST_PID;
                    cnt_d     = '0;
                    pkt_ok_d  = 1'b0;
                    pid_err_d = 1'b0;
                    len_err_d = 1'b0;
                    rx_err_d  = 1'b0;
`ifdef USB_PKT_CRC_CHECK_EN
                    crc_err_d = 1'b0;
                    crc5_d    = 5'h1F;
                    crc16_d   = 16'hFFFF;
`endif
                    take_pid  = valid;
                end
            end
            ST_PID: begin
                if (error) begin
                    rx_err_d = 1'b1;
                    state_d  = active ? ST_DRAIN : ST_END;
                end else if (!active) begin
                    len_err_d = 1'b1;
                    state_d   = ST_END;
                end else begin
                    take_pid = valid;
                end
            end
            ST_TOKEN: begin
                if (error) begin
                    rx_err_d = 1'b1;
                    state_d  = active ? ST_DRAIN : ST_END;
                end else if (!active) begin
                    if (cnt_q != TWO) len_err_d = 1'b1;
`ifdef USB_PKT_CRC_CHECK_EN
                    else if (crc5_q != CRC5_RES) crc_err_d = 1'b1;
`endif
                    state_d = ST_END;
                end else if (valid) begin
                    if (cnt_q == TWO) begin
                        len_err_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + ONE;
`ifdef USB_PKT_CRC_CHECK_EN
                        crc5_d = crc5_byte(crc5_q, data);
`endif
                        if (cnt_q == '0) begin
                            b1_d = data;
                        end else begin
                            addr_d  = b1_q[6:0];
                            endp_d  = {data[2:0], b1_q[7]};
                            frame_d = {data[2:0], b1_q};
                        end
                    end
                end
            end
            ST_DATA: begin
                if (error) begin
                    rx_err_d = 1'b1;
                    state_d  = active ? ST_DRAIN : ST_END;
                end else if (!active) begin
                    if (cnt_q < TWO) len_err_d = 1'b1;
`ifdef USB_PKT_CRC_CHECK_EN
                    else if (crc16_q != CRC16_RES) crc_err_d = 1'b1;
`endif
                    state_d = ST_END;
                end else if (valid) begin
                    if (cnt_q == DATA_LIM) begin
                        len_err_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        // Two-byte delay line: the final two bytes (CRC16) never leave it.
                        cnt_d  = cnt_q + ONE;
                        buf0_d = buf1_q;
                        buf1_d = data;
                        if (cnt_q >= TWO) begin
                            dout_d   = buf0_q;
                            dvalid_d = 1'b1;
                        end
`ifdef USB_PKT_CRC_CHECK_EN
                        crc16_d = crc16_byte(crc16_q, data);
`endif
                    end
                end
            end
            ST_HSK: begin
                if (error) begin
                    rx_err_d = 1'b1;
                    state_d  = active ? ST_DRAIN : ST_END;
                end else if (!active) begin
                    state_d = ST_END;
                end else if (valid) begin
                    len_err_d = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (error && !silent_q) rx_err_d = 1'b1;
                if (!active) begin
                    state_d  = silent_q ? ST_IDLE : ST_END;
                    silent_d = 1'b0;
                end
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (take_pid) begin
            if (data[3:0] == ~data[7:4]) begin
                pid_d = data[3:0];
                case (data[1:0])
                    2'b01:   state_d = ST_TOKEN;
                    2'b11:   state_d = ST_DATA;
                    2'b10:   state_d = ST_HSK;
                    default: begin
                        pid_err_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                endcase
            end else begin
                pid_err_d = 1'b1;
                state_d   = ST_DRAIN;
            end
        end

`ifdef USB_PKT_CRC_CHECK_EN
        crc_flag_d = crc_err_d;
`else
        crc_flag_d = 1'b0;
`endif
        pkt_end_d = (state_d == ST_END);
        if (state_d == ST_END) pkt_ok_d = ~(pid_err_d | crc_flag_d | len_err_d | rx_err_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            b1_q      <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            silent_q  <= 1'b1;
            pid_q     <= '0;
            addr_q    <= '0;
            endp_q    <= '0;
            frame_q   <= '0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            pkt_end_q <= 1'b0;
            pkt_ok_q  <= 1'b0;
            pid_err_q <= 1'b0;
            len_err_q <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b1_q      <= b1_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            silent_q  <= silent_d;
            pid_q     <= pid_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
            frame_q   <= frame_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            pkt_end_q <= pkt_end_d;
            pkt_ok_q  <= pkt_ok_d;
            pid_err_q <= pid_err_d;
            len_err_q <= len_err_d;
            rx_err_q  <= rx_err_d;
        end
    end

`ifdef USB_PKT_CRC_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc5_q    <= 5'h1F;
            crc16_q   <= 16'hFFFF;
            crc_err_q <= 1'b0;
        end else begin
            crc5_q    <= crc5_d;
            crc16_q   <= crc16_d;
            crc_err_q <= crc_err_d;
        end
    end
    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    assign pid        = pid_q;
    assign addr       = addr_q;
    assign endp       = endp_q;
    assign frame      = frame_q;
    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
    assign pkt_end    = pkt_end_q;
    assign pkt_ok     = pkt_ok_q;
    assign pid_err    = pid_err_q;
    assign len_err    = len_err_q;
    assign rx_err     = rx_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Bench for usb_pkt_rx: directed packets plus random packets checked against a packet-level model.
module tb_usb_pkt_rx;
    localparam int MAX_DATA = 8;
`ifdef USB_PKT_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk, rst, active, valid, error;
    logic [7:0]  data;
    logic [3:0]  pid, endp;
    logic [6:0]  addr;
    logic [10:0] frame;
    logic [7:0]  data_out;
    logic        data_valid, pkt_end, pkt_ok, pid_err, crc_err, len_err, rx_err;
    logic [2:0]  state_dbg;

    usb_pkt_rx #(.MAX_DATA(MAX_DATA)) dut (
        .clk(clk), .rst(rst), .active(active), .valid(valid), .error(error), .data(data),
        .pid(pid), .addr(addr), .endp(endp), .frame(frame),
        .data_out(data_out), .data_valid(data_valid), .pkt_end(pkt_end), .pkt_ok(pkt_ok),
        .pid_err(pid_err), .crc_err(crc_err), .len_err(len_err), .rx_err(rx_err),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // monitor: collects emitted payload bytes and the status seen on the pkt_end cycle
    logic [7:0]  got_q[$];
    int          end_cnt = 0;
    logic        s_ok, s_pid_err, s_crc_err, s_len_err, s_rx_err;
    logic [3:0]  s_pid, s_endp;
    logic [6:0]  s_addr;
    logic [10:0] s_frame;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) got_q.push_back(data_out);
            if (pkt_end) begin
                end_cnt++;
                s_ok = pkt_ok; s_pid_err = pid_err; s_crc_err = crc_err;
                s_len_err = len_err; s_rx_err = rx_err;
                s_pid = pid; s_addr = addr; s_endp = endp; s_frame = frame;
            end
        end
    end

    // packet under construction and reference model state
    logic [7:0]  pkt_q[$];
    int          err_at = -1;
    logic [7:0]  exp_q[$];
    logic [3:0]  m_pid = '0, m_endp = '0;
    logic [6:0]  m_addr = '0;
    logic [10:0] m_frame = '0;
    logic        e_pid_err, e_crc_err, e_len_err, e_rx_err;

    function automatic logic [4:0] crc5_tx(input logic [10:0] bits);
        logic [4:0] c, x, r;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (bits[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else                c = {c[3:0], 1'b0};
        end
        x = ~c;
        for (int i = 0; i < 5; i++) r[i] = x[4 - i];
        return r;
    endfunction

    // Returns the two CRC16 bytes to transmit after pkt_q[first +: len], first byte in [15:8].
    function automatic logic [15:0] crc16_tx(input int first, input int len);
        logic [15:0] c, x, r;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 0; k < len; k++) begin
            b = pkt_q[first + k];
            for (int i = 0; i < 8; i++) begin
                if (b[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
                else              c = {c[14:0], 1'b0};
            end
        end
        x = ~c;
        for (int i = 0; i < 8; i++) begin
            r[8 + i] = x[15 - i];
            r[i]     = x[7 - i];
        end
        return r;
    endfunction

    task automatic build_token(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e);
        logic [4:0] r;
        r = crc5_tx({e, a});
        pkt_q = {};
        pkt_q.push_back(p);
        pkt_q.push_back({e[0], a});
        pkt_q.push_back({r, e[3:1]});
    endtask

    task automatic build_data(input logic [7:0] p, input int len);
        logic [15:0] c;
        pkt_q = {};
        pkt_q.push_back(p);
        for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
        c = crc16_tx(1, len);
        pkt_q.push_back(c[15:8]);
        pkt_q.push_back(c[7:0]);
    endtask

    // Packet-level reference: expected status, fields and payload from the byte list alone.
    task automatic model_pkt();
        int n;
        logic [7:0] p, b1, b2, c0, c1;
        logic [15:0] c;
        exp_q.delete();
        e_pid_err = 0; e_crc_err = 0; e_len_err = 0; e_rx_err = 0;
        if (pkt_q.size() == 0) begin
            e_len_err = 1;
            return;
        end
        p = pkt_q[0];
        n = pkt_q.size() - 1;
        if (p[3:0] != ~p[7:4]) begin
            e_pid_err = 1;
            return;
        end
        m_pid = p[3:0];
        case (p[1:0])
            2'b00: e_pid_err = 1;
            2'b10: if (n != 0) e_len_err = 1;
            2'b01: begin
                if (n >= 2) begin
                    b1 = pkt_q[1]; b2 = pkt_q[2];
                    m_addr = b1[6:0]; m_endp = {b2[2:0], b1[7]}; m_frame = {b2[2:0], b1};
                    if (n != 2) e_len_err = 1;
                    else if (CRC_EN && crc5_tx({b2[2:0], b1}) != b2[7:3]) e_crc_err = 1;
                end else begin
                    e_len_err = 1;
                end
            end
            default: begin
                if (n < 2) begin
                    e_len_err = 1;
                end else if (n - 2 > MAX_DATA) begin
                    e_len_err = 1;
                    for (int i = 0; i < MAX_DATA; i++) exp_q.push_back(pkt_q[1 + i]);
                end else begin
                    for (int i = 0; i < n - 2; i++) exp_q.push_back(pkt_q[1 + i]);
                    c = crc16_tx(1, n - 2);
                    c0 = pkt_q[n - 1]; c1 = pkt_q[n];
                    if (CRC_EN && c != {c0, c1}) e_crc_err = 1;
                end
            end
        endcase
    endtask

    // driver
    task automatic drive_pkt(input bit same_cycle);
        @(negedge clk);
        active = 1'b1;
        if (!same_cycle) @(negedge clk);
        foreach (pkt_q[i]) begin
            valid = 1'b1;
            data  = pkt_q[i];
            error = (i == err_at);
            @(negedge clk);
            valid = 1'b0;
            error = 1'b0;
            data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        active = 1'b0;
    endtask

    task automatic wait_end(input int e0, input string tag);
        int k;
        k = 0;
        while (end_cnt == e0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, " pkt_end_seen"}, (end_cnt != e0), 1);
        repeat (3) @(negedge clk);
        check({tag, " pkt_end_once"}, end_cnt - e0, 1);
    endtask

    task automatic run_pkt(input string tag, input bit same_cycle);
        int st, e0;
        logic e_ok;
        model_pkt();
        e_ok = ~(e_pid_err | e_crc_err | e_len_err | e_rx_err);
        st = got_q.size();
        e0 = end_cnt;
        drive_pkt(same_cycle);
        wait_end(e0, tag);
        check({tag, " pkt_ok"}, s_ok, e_ok);
        check({tag, " pid_err"}, s_pid_err, e_pid_err);
        check({tag, " crc_err"}, s_crc_err, e_crc_err);
        check({tag, " len_err"}, s_len_err, e_len_err);
        check({tag, " rx_err"}, s_rx_err, e_rx_err);
        check({tag, " pid"}, s_pid, m_pid);
        check({tag, " addr"}, s_addr, m_addr);
        check({tag, " endp"}, s_endp, m_endp);
        check({tag, " frame"}, s_frame, m_frame);
        check({tag, " pkt_ok_held"}, pkt_ok, e_ok);
        check({tag, " n_data"}, got_q.size() - st, exp_q.size());
        foreach (exp_q[i])
            if (st + i < got_q.size()) check({tag, " data_byte"}, got_q[st + i], exp_q[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " pid"}, pid, 0);
        check({tag, " addr"}, addr, 0);
        check({tag, " endp"}, endp, 0);
        check({tag, " frame"}, frame, 0);
        check({tag, " data_out"}, data_out, 0);
        check({tag, " data_valid"}, data_valid, 0);
        check({tag, " pkt_end"}, pkt_end, 0);
        check({tag, " status"}, {pkt_ok, pid_err, crc_err, len_err, rx_err}, 0);
    endtask

    initial begin
        int st, e0, kind, len;
        logic [7:0] b;
        rst = 1'b1; active = 1'b0; valid = 1'b0; error = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ACK
        pkt_q = {8'hD2};
        run_pkt("ack", 1'b0);
        check("ack pid", s_pid, 4'h2);
        check("ack ok", s_ok, 1);

        // SETUP addr 0 endp 0, then the same with a corrupted CRC5 byte
        pkt_q = {8'h2D, 8'h00, 8'h10};
        run_pkt("setup", 1'b0);
        check("setup pid", s_pid, 4'hD);
        check("setup addr", s_addr, 0);
        check("setup endp", s_endp, 0);
        pkt_q = {8'h2D, 8'h00, 8'h11};
        run_pkt("setup_badcrc", 1'b1);

        // zero-length DATA0, then a three-byte payload
        pkt_q = {8'hC3, 8'h00, 8'h00};
        run_pkt("data0_empty", 1'b0);
        check("data0_empty ok", s_ok, 1);
        build_data(8'hC3, 0);
        pkt_q = {8'hC3, 8'h01, 8'h02, 8'h03};
        begin
            logic [15:0] c;
            c = crc16_tx(1, 3);
            pkt_q.push_back(c[15:8]);
            pkt_q.push_back(c[7:0]);
        end
        run_pkt("data0_123", 1'b0);

        // bad PID, oversize DATA1, empty packet
        pkt_q = {8'hC2, 8'h00, 8'h00};
        run_pkt("bad_pid", 1'b0);
        check("bad_pid pid_err", s_pid_err, 1);
        build_data(8'h4B, 9);
        run_pkt("data1_long", 1'b0);
        check("data1_long len_err", s_len_err, 1);
        pkt_q = {};
        run_pkt("empty", 1'b0);

        // receive error on the second token byte
        build_token(8'hE1, 7'h55, 4'h9);
        err_at = 2;
        e0 = end_cnt;
        drive_pkt(1'b0);
        wait_end(e0, "rx_err");
        err_at = -1;
        check("rx_err rx_err", s_rx_err, 1);
        check("rx_err pkt_ok", s_ok, 0);
        check("rx_err pid", s_pid, 4'h1);
        check("rx_err addr_held", s_addr, m_addr);
        m_pid = 4'h1;

        // reset in the middle of a DATA packet, with active still high at release
        @(negedge clk);
        active = 1'b1;
        foreach (pkt_q[i]) pkt_q.delete(i);
        pkt_q = {8'hC3, 8'h11, 8'h22, 8'h33};
        @(negedge clk);
        foreach (pkt_q[i]) begin
            valid = 1'b1; data = pkt_q[i];
            @(negedge clk);
        end
        valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        m_pid = '0; m_addr = '0; m_endp = '0; m_frame = '0;
        @(negedge clk);
        rst = 1'b0;
        st = got_q.size();
        e0 = end_cnt;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; data = 8'h40 + 8'(i);
            @(negedge clk);
        end
        valid = 1'b0;
        @(negedge clk);
        active = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst no_pkt_end", end_cnt - e0, 0);
        check("mid_rst no_data", got_q.size() - st, 0);
        check_zero("post_rst");

        // random traffic
        for (int t = 0; t < 48; t++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    case ($urandom_range(0, 2))
                        0: b = 8'hD2;
                        1: b = 8'h5A;
                        default: b = 8'h1E;
                    endcase
                    pkt_q = {b};
                    if ($urandom_range(0, 3) == 0) pkt_q.push_back(8'($urandom));
                end
                1: begin
                    case ($urandom_range(0, 3))
                        0: b = 8'hE1;
                        1: b = 8'h69;
                        2: b = 8'hA5;
                        default: b = 8'h2D;
                    endcase
                    build_token(b, 7'($urandom), 4'($urandom));
                    if ($urandom_range(0, 3) == 0) pkt_q[1 + $urandom_range(0, 1)] ^= 8'(1 << $urandom_range(0, 7));
                    if ($urandom_range(0, 7) == 0) void'(pkt_q.pop_back());
                    else if ($urandom_range(0, 7) == 0) pkt_q.push_back(8'($urandom));
                end
                2, 3: begin
                    len = $urandom_range(0, MAX_DATA + 2);
                    build_data(($urandom_range(0, 1) == 0) ? 8'hC3 : 8'h4B, len);
                    if ($urandom_range(0, 3) == 0) pkt_q[$urandom_range(1, len + 2)] ^= 8'(1 << $urandom_range(0, 7));
                end
                4: begin
                    b = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) b = 8'hF0;
                    else if (b[3:0] == ~b[7:4]) b[4] = ~b[4];
                    pkt_q = {b};
                    repeat ($urandom_range(0, 3)) pkt_q.push_back(8'($urandom));
                end
                default: begin
                    pkt_q = {($urandom_range(0, 1) == 0) ? 8'hC3 : 8'h4B};
                    if ($urandom_range(0, 1) == 0) pkt_q.push_back(8'($urandom));
                end
            endcase
            run_pkt($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
